mem_write_arbiter: RTL and testbench
====================================

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, write address width.
REQ-002 SHALL have parameter DATA_W, default 18, write data width.
REQ-003 SHALL have parameter MEMSIZE, default 5120, number of valid words per bank.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester n offers a write.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  requester n's write accepted this cycle (combinational).
REQ-008 SHALL have ports req0_bank / req1_bank  input  1  target bank (0 = bank a, 1 = bank b).
REQ-009 SHALL have ports req0_addr / req1_addr  input  ADDR_W  word address.
REQ-010 SHALL have ports req0_data / req1_data  input  DATA_W  write data.
REQ-011 SHALL have port hold  input  1  suppresses all grants while high.
REQ-012 SHALL have port mem_write_sel  output  2  bank select to the image memory (0 = a, 1 = b).
REQ-013 SHALL have ports mem_write_addr_a / mem_write_addr_b  output  ADDR_W  registered write address.
REQ-014 SHALL have ports mem_write_data_a / mem_write_data_b  output  DATA_W  registered write data.
REQ-015 SHALL have ports mem_write_en_a / mem_write_en_b  output  1  registered write strobe.
REQ-016 SHALL have port err_oob  output  1  one-cycle pulse: accepted write had addr >= MEMSIZE.
REQ-017 SHALL have ports cnt0 / cnt1  output  16  saturating count of writes accepted per requester.

Function
REQ-018 SHALL grant at most one request per cycle; transfer occurs when reqN_valid && reqN_ready.
REQ-019 SHALL keep a priority state: PRI0 (req0 preferred) or PRI1 (req1 preferred).
REQ-020 SHALL, when both valid and hold low, grant the preferred requester; after the grant, state moves to favour the other requester.
REQ-021 SHALL, when only one valid and hold low, grant it; state moves to favour the other requester.
REQ-022 SHALL, when neither is valid or hold is high, assert no ready and leave the state unchanged.
REQ-023 SHALL register a granted write to the memory ports on the edge of acceptance (latency 1 cycle): bank 0 drives mem_write_sel=0, mem_write_en_a=1, addr/data_a; bank 1 drives mem_write_sel=1, mem_write_en_b=1, addr/data_b.
REQ-024 SHALL, in cycles with no accepted in-range write, drive mem_write_en_a=0 and mem_write_en_b=0; addr/data/sel registers hold their previous values.
REQ-025 SHALL never assert mem_write_en_a and mem_write_en_b in the same cycle.
REQ-026 SHALL accept (ready high) a write with addr >= MEMSIZE, not issue a strobe for it, and pulse err_oob for exactly the following cycle.
REQ-027 SHALL increment cntN by 1 on every accepted write from requester N, including out-of-range ones; it saturates at 16'hFFFF.
REQ-028 SHALL make readyN depend only on valid inputs, hold and the priority state (no dependency on addr/data).
REQ-029 SHALL allow back-to-back grants every cycle; a single requester held valid is granted every cycle.

Reset
REQ-030 SHALL, while rst_n is low, asynchronously force state PRI0, mem_write_en_a=0, mem_write_en_b=0, mem_write_sel=0, all mem addr/data=0, err_oob=0, cnt0=cnt1=0.
REQ-031 SHALL force req0_ready=req1_ready=0 while rst_n is low.
REQ-032 SHALL, when reset asserts in the cycle after an acceptance, drop the pending strobe; no write reaches memory.

Verification
REQ-033 After reset, req0 valid bank0 addr 3 data 30 only -> req0_ready=1; next cycle mem_write_en_a=1, addr_a=3, data_a=30, sel=0; cnt0=1.
REQ-034 Both valid continuously for 4 cycles (req0 bank0, req1 bank1) -> grants alternate 0,1,0,1; write strobes alternate en_a/en_b; cnt0=cnt1=2.
REQ-035 req1 bank1 addr 5120 -> ready=1; no en_b next cycle; err_oob=1 for one cycle; cnt1 increments.
REQ-036 Both valid with hold=1 for 3 cycles, then hold=0 -> no ready during hold; first grant after hold goes to the requester preferred before hold.
REQ-037 Drive 65536 accepted writes on req0 -> cnt0 reaches and stays 16'hFFFF.
REQ-038 Assert rst_n=0 mid-stream, one cycle after acceptance -> en_a/en_b go 0 immediately; cnt0/cnt1 = 0; state PRI0 after release.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// Two-requester write arbiter in front of a two-bank image memory.
// Alternating priority, one registered write per cycle, out-of-range writes are flagged and dropped.
module mem_write_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 18,
  parameter int MEMSIZE = 5120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_bank,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_bank,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              hold,
  output logic [1:0]        mem_write_sel,
  output logic [ADDR_W-1:0] mem_write_addr_a,
  output logic [ADDR_W-1:0] mem_write_addr_b,
  output logic [DATA_W-1:0] mem_write_data_a,
  output logic [DATA_W-1:0] mem_write_data_b,
  output logic              mem_write_en_a,
  output logic              mem_write_en_b,
  output logic              err_oob,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  output logic              dbg_state
);

  // Handshake: a write transfers in the cycle where reqN_valid && reqN_ready are both high
  // at the rising edge; ready is combinational from valids, hold and priority state only.

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEMSIZE);

  pri_t              state, state_nxt;
  logic              g_any;
  logic              g_bank;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              g_oob;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRI0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && !hold) begin
      if (req0_valid && (state == PRI0 || !req1_valid)) begin
        req0_ready = 1'b1;
        state_nxt  = PRI1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
        state_nxt  = PRI0;
      end
    end
  end

  always_comb begin
    g_any  = req0_ready | req1_ready;
    g_bank = req1_ready ? req1_bank : req0_bank;
    g_addr = req1_ready ? req1_addr : req0_addr;
    g_data = req1_ready ? req1_data : req0_data;
    g_oob  = {1'b0, g_addr} >= MEM_LIM;
  end

  // Strobes and err_oob are single-cycle; address/data/sel registers keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write_sel    <= 2'd0;
      mem_write_addr_a <= '0;
      mem_write_addr_b <= '0;
      mem_write_data_a <= '0;
      mem_write_data_b <= '0;
      mem_write_en_a   <= 1'b0;
      mem_write_en_b   <= 1'b0;
      err_oob          <= 1'b0;
      cnt0             <= 16'd0;
      cnt1             <= 16'd0;
    end else begin
      mem_write_en_a <= 1'b0;
      mem_write_en_b <= 1'b0;
      err_oob        <= 1'b0;
      if (g_any) begin
        if (g_oob) begin
          err_oob <= 1'b1;
        end else if (g_bank) begin
          mem_write_en_b   <= 1'b1;
          mem_write_sel    <= 2'd1;
          mem_write_addr_b <= g_addr;
          mem_write_data_b <= g_data;
        end else begin
          mem_write_en_a   <= 1'b1;
          mem_write_sel    <= 2'd0;
          mem_write_addr_a <= g_addr;
          mem_write_data_a <= g_data;
        end
      end
      if (req0_ready && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (req1_ready && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: directed scenarios plus random traffic against a
// transaction-level model (winner choice, saturating counts, queue of expected memory writes).
module tb_mem_write_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 18;
  localparam int MEMSIZE = 5120;
  localparam int WW      = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic              req0_bank = 1'b0, req1_bank = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              hold = 1'b0;
  logic [1:0]        mem_write_sel;
  logic [ADDR_W-1:0] mem_write_addr_a, mem_write_addr_b;
  logic [DATA_W-1:0] mem_write_data_a, mem_write_data_b;
  logic              mem_write_en_a, mem_write_en_b, err_oob;
  logic [15:0]       cnt0, cnt1;
  logic              dbg_state;

  mem_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEMSIZE(MEMSIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bank(req0_bank),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bank(req1_bank),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .hold(hold), .mem_write_sel(mem_write_sel),
    .mem_write_addr_a(mem_write_addr_a), .mem_write_addr_b(mem_write_addr_b),
    .mem_write_data_a(mem_write_data_a), .mem_write_data_b(mem_write_data_b),
    .mem_write_en_a(mem_write_en_a), .mem_write_en_b(mem_write_en_b),
    .err_oob(err_oob), .cnt0(cnt0), .cnt1(cnt1), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int unsigned       vectors = 0;
  int unsigned       miscompares = 0;
  int                m_pref;
  int                m_cnt0, m_cnt1;
  logic              e_en_a, e_en_b, e_err;
  logic [1:0]        e_sel;
  logic [ADDR_W-1:0] e_addr_a, e_addr_b;
  logic [DATA_W-1:0] e_data_a, e_data_b;
  logic [WW-1:0]     exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pref = 0; m_cnt0 = 0; m_cnt1 = 0;
    e_en_a = 0; e_en_b = 0; e_err = 0; e_sel = 0;
    e_addr_a = 0; e_addr_b = 0; e_data_a = 0; e_data_b = 0;
    exp_q.delete();
  endtask

  task automatic set_req(input int n, input logic v, input logic b,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (n == 0) begin req0_valid = v; req0_bank = b; req0_addr = a; req0_data = d; end
    else        begin req1_valid = v; req1_bank = b; req1_addr = a; req1_data = d; end
  endtask

  // Reset with traffic offered; readies and registers must be cleared asynchronously.
  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'd1, 18'd1);
    set_req(1, 1'b1, 1'b1, 16'd2, 18'd2);
    hold = 1'b0;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_en_a", mem_write_en_a, 0);
    chk("rst_en_b", mem_write_en_b, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_err", err_oob, 0);
    chk("rst_sel", mem_write_sel, 0);
    chk("rst_addr_a", mem_write_addr_a, 0);
    chk("rst_data_b", mem_write_data_b, 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    set_req(0, 1'b0, 1'b0, 16'd0, 18'd0);
    set_req(1, 1'b0, 1'b0, 16'd0, 18'd0);
  endtask

  // One clock: inputs are already driven just after a negedge; returns at the next negedge.
  task automatic step(input bit full);
    int w;
    logic              wb;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [WW-1:0]     got, exp;
    #1;
    if (hold)                          w = -1;
    else if (req0_valid && req1_valid) w = m_pref;
    else if (req0_valid)               w = 0;
    else if (req1_valid)               w = 1;
    else                               w = -1;
    if (full) begin
      chk("ready0", req0_ready, (w == 0) ? 1 : 0);
      chk("ready1", req1_ready, (w == 1) ? 1 : 0);
    end
    e_en_a = 0; e_en_b = 0; e_err = 0;
    if (w >= 0) begin
      m_pref = 1 - w;
      wb = (w == 0) ? req0_bank : req1_bank;
      wa = (w == 0) ? req0_addr : req1_addr;
      wd = (w == 0) ? req0_data : req1_data;
      if (w == 0 && m_cnt0 < 65535) m_cnt0++;
      if (w == 1 && m_cnt1 < 65535) m_cnt1++;
      if (int'(wa) >= MEMSIZE) e_err = 1;
      else begin
        exp_q.push_back({wb, wa, wd});
        e_sel = {1'b0, wb};
        if (wb) begin e_en_b = 1; e_addr_b = wa; e_data_b = wd; end
        else    begin e_en_a = 1; e_addr_a = wa; e_data_a = wd; end
      end
    end
    @(posedge clk);
    #1;
    if (full) begin
      chk("en_a", mem_write_en_a, e_en_a);
      chk("en_b", mem_write_en_b, e_en_b);
      chk("err_oob", err_oob, e_err);
      chk("sel", mem_write_sel, e_sel);
      chk("addr_a", mem_write_addr_a, e_addr_a);
      chk("data_a", mem_write_data_a, e_data_a);
      chk("addr_b", mem_write_addr_b, e_addr_b);
      chk("data_b", mem_write_data_b, e_data_b);
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
      chk("state", dbg_state, m_pref);
      chk("en_exclusive", mem_write_en_a & mem_write_en_b, 0);
    end
    // scoreboard: every observed strobe must match the oldest expected write
    if (mem_write_en_a || mem_write_en_b) begin
      chk("sb_pending", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = mem_write_en_b ? {1'b1, mem_write_addr_b, mem_write_data_b}
                             : {1'b0, mem_write_addr_a, mem_write_data_a};
        chk("sb_write", got, exp);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'(MEMSIZE - 2 + $urandom_range(0, 3));
    return ADDR_W'($urandom_range(0, MEMSIZE - 1));
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single write on req0, bank a
    set_req(0, 1'b1, 1'b0, 16'd3, 18'd30);
    step(1);
    set_req(0, 1'b0, 1'b0, 16'd0, 18'd0);
    step(1);

    // both valid for 4 cycles from PRI0: grants 0,1,0,1
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'd10, 18'd100);
    set_req(1, 1'b1, 1'b1, 16'd20, 18'd200);
    for (int i = 0; i < 4; i++) begin
      req0_addr = 16'(10 + i); req1_addr = 16'(20 + i);
      step(1);
    end
    set_req(0, 1'b0, 1'b0, 16'd0, 18'd0);
    set_req(1, 1'b0, 1'b0, 16'd0, 18'd0);
    step(1);

    // out-of-range on req1 at the exact boundary, then just inside it
    set_req(1, 1'b1, 1'b1, 16'(MEMSIZE), 18'h3ffff);
    step(1);
    set_req(1, 1'b1, 1'b1, 16'(MEMSIZE - 1), 18'h2aaaa);
    step(1);
    set_req(1, 1'b0, 1'b0, 16'd0, 18'd0);
    step(1);

    // hold for 3 cycles with both valid, then release
    set_req(0, 1'b1, 1'b1, 16'd7, 18'd70);
    set_req(1, 1'b1, 1'b0, 16'd8, 18'd80);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step(1);
    hold = 1'b0;
    step(1);
    step(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 18'($urandom));
      set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 18'($urandom));
      hold = ($urandom_range(0, 5) == 0);
      step(1);
    end
    hold = 1'b0;

    // counter saturation on req0
    do_reset();
    set_req(1, 1'b0, 1'b0, 16'd0, 18'd0);
    for (int i = 0; i < 65536; i++) begin
      set_req(0, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, MEMSIZE - 1)), 18'($urandom));
      step(0);
    end
    for (int i = 0; i < 3; i++) step(1);

    // reset one cycle after an acceptance drops the strobe
    set_req(0, 1'b1, 1'b0, 16'd44, 18'd440);
    step(1);
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'd45, 18'd450);
    set_req(1, 1'b1, 1'b1, 16'd46, 18'd460);
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
